// File: rtl/ps2_hex_keyboard_pkg.sv
// Shared constants, prefix-state encoding and the Set-2 hex key lookup.
package ps2_hex_keyboard_pkg;

  localparam int unsigned FRAME_LEN = 11;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NIB_W     = 4;

  localparam logic [BYTE_W-1:0] BREAK_CODE = 8'hF0;
  localparam logic [BYTE_W-1:0] EXT_CODE   = 8'hE0;

  typedef struct packed {
    logic             hit;
    logic [NIB_W-1:0] nibble;
  } hex_hit_t;

  typedef enum logic [1:0] {
    PFX_IDLE,
    PFX_BREAK,
    PFX_EXT,
    PFX_EXT_BREAK
  } pfx_state_t;

  // Set-2 make code to hex nibble; hit=0 for any other key.
  function automatic hex_hit_t hex_lookup(input logic [BYTE_W-1:0] code);
    hex_hit_t r;
    r = '{hit: 1'b1, nibble: 4'h0};
    case (code)
      8'h45: r.nibble = 4'h0;
      8'h16: r.nibble = 4'h1;
      8'h1E: r.nibble = 4'h2;
      8'h26: r.nibble = 4'h3;
      8'h25: r.nibble = 4'h4;
      8'h2E: r.nibble = 4'h5;
      8'h36: r.nibble = 4'h6;
      8'h3D: r.nibble = 4'h7;
      8'h3E: r.nibble = 4'h8;
      8'h46: r.nibble = 4'h9;
      8'h1C: r.nibble = 4'hA;
      8'h32: r.nibble = 4'hB;
      8'h21: r.nibble = 4'hC;
      8'h23: r.nibble = 4'hD;
      8'h24: r.nibble = 4'hE;
      8'h2B: r.nibble = 4'hF;
      default: r = '{hit: 1'b0, nibble: 4'h0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_hex_keyboard_rx.sv
// PS/2 device-to-host frame receiver: sync, glitch filter, deserialiser, checks.
module ps2_rx
  import ps2_hex_keyboard_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kbdclk,
  input  logic              kbddat,
  output logic              byte_stb,
  output logic [BYTE_W-1:0] byte_out,
  output logic              frame_err
);

  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W  = $clog2(FRAME_LEN);

  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] dat_dly;
  logic                  filt_clk;
  logic [FILT_W-1:0]     filt_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [BYTE_W:0]       sreg;
  logic [TO_W-1:0]       idle_cnt;
  logic                  flip_c;
  logic                  fall_c;
  logic                  samp_c;

  // New kbdclk level accepted on its FILTER_LEN-th consecutive sample.
  assign flip_c = (clk_sync[1] != filt_clk) && (filt_cnt == FILT_W'(FILTER_LEN - 1));
  assign fall_c = flip_c && filt_clk;
  // Data delayed by the filter depth so it lines up with the filtered clock.
  assign samp_c = dat_dly[FILTER_LEN-1];

  // Two-flop synchronisers plus data delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      dat_dly  <= '1;
    end else begin
      clk_sync <= {clk_sync[0], kbdclk};
      dat_sync <= {dat_sync[0], kbddat};
      dat_dly  <= {dat_dly[FILTER_LEN-2:0], dat_sync[1]};
    end
  end

  // Glitch filter on the synchronised keyboard clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == filt_clk) begin
      filt_cnt <= '0;
    end else if (flip_c) begin
      filt_clk <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  // Bit counter, shift register, frame check and idle timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      sreg      <= '0;
      idle_cnt  <= '0;
      byte_stb  <= 1'b0;
      byte_out  <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (fall_c) begin
        idle_cnt <= '0;
        if (bit_cnt == '0) begin
          if (samp_c) frame_err <= 1'b1;
          else        bit_cnt   <= CNT_W'(1);
        end else if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
          bit_cnt <= '0;
          // sreg holds data plus parity; odd parity means the XOR is 1.
          if (samp_c && (^sreg)) begin
            byte_stb <= 1'b1;
            byte_out <= sreg[BYTE_W-1:0];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          sreg    <= {samp_c, sreg[BYTE_W:1]};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if ((bit_cnt == '0) || flip_c) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_hex_keyboard.sv
// PS/2 keyboard receiver with break/extended prefix tracking and hex decode.
module ps2_hex_keyboard
  import ps2_hex_keyboard_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kbdclk,
  input  logic              kbddat,
  output logic [BYTE_W-1:0] decoded,
  output logic [NIB_W-1:0]  kbout,
  output logic              key_valid,
  output logic              released,
  output logic              frame_err
);

  logic              rx_stb;
  logic [BYTE_W-1:0] rx_byte;
  pfx_state_t        state;
  pfx_state_t        state_nx;
  logic [BYTE_W-1:0] decoded_nx;
  logic [NIB_W-1:0]  kbout_nx;
  logic              released_nx;
  logic              key_valid_nx;
  logic              brk_c;
  hex_hit_t          lk;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .kbdclk   (kbdclk),
    .kbddat   (kbddat),
    .byte_stb (rx_stb),
    .byte_out (rx_byte),
    .frame_err(frame_err)
  );

  // Prefix state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PFX_IDLE;
      decoded   <= '0;
      kbout     <= '0;
      released  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      decoded   <= decoded_nx;
      kbout     <= kbout_nx;
      released  <= released_nx;
      key_valid <= key_valid_nx;
    end
  end

  // Prefix tracking and output update for each received byte.
  always_comb begin
    state_nx     = state;
    decoded_nx   = decoded;
    kbout_nx     = kbout;
    released_nx  = released;
    key_valid_nx = 1'b0;
    lk           = hex_lookup(rx_byte);
    brk_c        = (state == PFX_BREAK) || (state == PFX_EXT_BREAK);
    if (rx_stb) begin
      if (rx_byte == BREAK_CODE) begin
        state_nx = ((state == PFX_EXT) || (state == PFX_EXT_BREAK)) ? PFX_EXT_BREAK : PFX_BREAK;
      end else if (rx_byte == EXT_CODE) begin
        state_nx = brk_c ? PFX_EXT_BREAK : PFX_EXT;
      end else begin
        state_nx   = PFX_IDLE;
        decoded_nx = rx_byte;
        if (lk.hit) begin
          kbout_nx     = lk.nibble;
          released_nx  = brk_c;
          key_valid_nx = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_hex_keyboard.sv
// Directed bench for ps2_hex_keyboard with a scan-code level reference model.
module tb_ps2_hex_keyboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       kbdclk;
  logic       kbddat;
  logic [7:0] decoded;
  logic [3:0] kbout;
  logic       key_valid;
  logic       released;
  logic       frame_err;

  int n_chk  = 0;
  int n_fail = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  logic [7:0] m_dec = 8'h00;
  logic [3:0] m_kb  = 4'h0;
  logic       m_rel = 1'b0;
  logic       m_brk = 1'b0;
  int         m_kv  = 0;

  logic [7:0] hex_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  ps2_hex_keyboard dut (
    .clk      (clk),
    .rst      (rst),
    .kbdclk   (kbdclk),
    .kbddat   (kbddat),
    .decoded  (decoded),
    .kbout    (kbout),
    .key_valid(key_valid),
    .released (released),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scan-code level model of what one accepted byte does to the outputs.
  task automatic model_byte(input logic [7:0] b);
    m_kv = 0;
    if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b != 8'hE0) begin
      m_dec = b;
      for (int k = 0; k < 16; k++) begin
        if (hex_codes[k] == b) begin
          m_kb  = 4'(k);
          m_rel = m_brk;
          m_kv  = 1;
        end
      end
      m_brk = 1'b0;
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic bad);
    logic p;
    p = ~(^b) ^ bad;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the first n bits of a frame; kbdclk half-period is 30 clk.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kbddat = bits[i];
      wait_clk(15);
      kbdclk = 1'b0;
      wait_clk(30);
      kbdclk = 1'b1;
      wait_clk(15);
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic bad);
    int kv0;
    int fe0;
    chk_en = 1'b0;
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_bits(mk(b, bad), 11);
    kbddat = 1'b1;
    if (!bad) model_byte(b);
    else      m_kv = 0;
    chk("key_valid_pulses", 32'(kv_cnt - kv0), 32'(m_kv));
    chk("frame_err_pulses", 32'(fe_cnt - fe0), bad ? 32'd1 : 32'd0);
    chk_en = 1'b1;
    wait_clk(30);
  endtask

  // Pulse counters for the one-cycle strobes.
  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
  end

  // Continuous compare against the model while the bus is idle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("decoded", 32'(decoded), 32'(m_dec));
      chk("kbout", 32'(kbout), 32'(m_kb));
      chk("released", 32'(released), 32'(m_rel));
      chk("key_valid_idle", 32'(key_valid), 32'd0);
      chk("frame_err_idle", 32'(frame_err), 32'd0);
    end
  end

  initial begin
    int kv0;
    int fe0;
    rst    = 1'b1;
    kbdclk = 1'b1;
    kbddat = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(10);
    chk("rst_decoded", 32'(decoded), 32'h00);
    chk("rst_kbout", 32'(kbout), 32'h0);
    chk("rst_released", 32'(released), 32'd0);
    chk_en = 1'b1;
    wait_clk(20);

    // Break sequence F0 2B.
    frame(8'hF0, 1'b0);
    chk("lit_after_f0_decoded", 32'(decoded), 32'h00);
    frame(8'h2B, 1'b0);
    chk("lit_2b_decoded", 32'(decoded), 32'h2B);
    chk("lit_2b_kbout", 32'(kbout), 32'hF);
    chk("lit_2b_released", 32'(released), 32'd1);

    // Make code 1C.
    frame(8'h1C, 1'b0);
    chk("lit_1c_kbout", 32'(kbout), 32'hA);
    chk("lit_1c_released", 32'(released), 32'd0);

    // Bad parity 2B leaves everything alone.
    frame(8'h2B, 1'b1);
    chk("lit_badpar_decoded", 32'(decoded), 32'h1C);
    chk("lit_badpar_kbout", 32'(kbout), 32'hA);

    // Non-hex Enter key.
    frame(8'h5A, 1'b0);
    chk("lit_5a_decoded", 32'(decoded), 32'h5A);
    chk("lit_5a_kbout", 32'(kbout), 32'hA);

    // Partial frame abandoned by timeout, then a full 45.
    chk_en = 1'b0;
    send_bits(mk(8'h16, 1'b0), 5);
    kbddat = 1'b1;
    chk_en = 1'b1;
    wait_clk(5100);
    frame(8'h45, 1'b0);
    chk("lit_45_decoded", 32'(decoded), 32'h45);
    chk("lit_45_kbout", 32'(kbout), 32'h0);

    // Extended prefix is consumed without effect.
    frame(8'hE0, 1'b0);
    frame(8'h25, 1'b0);
    chk("lit_e025_kbout", 32'(kbout), 32'h4);
    chk("lit_e025_released", 32'(released), 32'd0);

    // Pending break, partial frame, then reset mid-frame.
    frame(8'hF0, 1'b0);
    chk_en = 1'b0;
    send_bits(mk(8'h16, 1'b0), 4);
    kbddat = 1'b1;
    rst = 1'b1;
    wait_clk(3);
    chk("midrst_decoded", 32'(decoded), 32'h00);
    chk("midrst_kbout", 32'(kbout), 32'h0);
    chk("midrst_released", 32'(released), 32'd0);
    rst   = 1'b0;
    m_dec = 8'h00;
    m_kb  = 4'h0;
    m_rel = 1'b0;
    m_brk = 1'b0;
    wait_clk(10);
    chk_en = 1'b1;

    // Two-cycle kbdclk glitch with data low must not count as a bit.
    kv0 = kv_cnt;
    fe0 = fe_cnt;
    kbddat = 1'b0;
    wait_clk(10);
    kbdclk = 1'b0;
    wait_clk(2);
    kbdclk = 1'b1;
    wait_clk(10);
    kbddat = 1'b1;
    wait_clk(40);
    chk("glitch_frame_err", 32'(fe_cnt - fe0), 32'd0);
    chk("glitch_key_valid", 32'(kv_cnt - kv0), 32'd0);
    frame(8'h16, 1'b0);
    chk("lit_16_decoded", 32'(decoded), 32'h16);
    chk("lit_16_kbout", 32'(kbout), 32'h1);
    chk("lit_16_released", 32'(released), 32'd0);

    chk_en = 1'b0;
    wait_clk(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
